// File: rtl/reg_dump_reader_pkg.sv
// Shared widths, dump FSM state encoding and the address-range word count.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_dump_reader_pkg;

  // Register-file geometry, shared with the writeback path.
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  // Must hold 1..2^ADDR_W, hence one extra bit.
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Number of words in the inclusive range first..last.
  // The range wraps through the top of the address space.
  // first == last + 1 yields the full 2^ADDR_W words.
  function automatic logic [CNT_W-1:0] range_count(
    input logic [ADDR_W-1:0] first,
    input logic [ADDR_W-1:0] last
  );
    logic [ADDR_W-1:0] span;
    span = last - first;
    return {1'b0, span} + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dump_out_reg.sv
// Single-entry output register for dump words: holds data, address and the last flag.
// Latency: a loaded word is visible on the cycle after the load edge.
// Backpressure: the word holds while o_valid && !i_ready; a load is legal only when empty or draining.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_clr                   drop the held word (abort); data/addr keep their last value
//   i_load                  capture i_data/i_addr/i_last and raise o_valid
//   i_data, i_addr, i_last  word to capture
//   i_ready                 consumer accepts the held word when o_valid && i_ready
//   o_valid, o_data, o_addr, o_last  held word
module dump_out_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_last  <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_addr  <= i_addr;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      // Accepted with nothing behind it: the entry empties.
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_addr  = r_addr;
  assign o_last  = r_last;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks a wrapping register address range and streams each word out tagged with its address.
// Latency: first word is valid on the edge after the accepted start; 1 word/cycle with ready held high.
// Backpressure: valid/ready; the held word and the read pointer freeze while outReady is low.
//
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_start, i_abort           begin a dump (ignored while busy) / cancel back to idle
//   i_firstAddr, i_lastAddr    inclusive range, sampled on an accepted start
//   o_readAddress, i_readData  register-file read port (data is combinational)
//   o_outValid, i_outReady, o_outData, o_outAddr, o_outLast  output word stream
//   o_busy, o_holdWrites       dump in progress; writeback must stall while high
//   o_done                     one-cycle pulse after the final word's handshake
module reg_dump_reader #(
  parameter int ADDR_W = reg_dump_reader_pkg::ADDR_W,
  parameter int DATA_W = reg_dump_reader_pkg::DATA_W,
  parameter int CNT_W  = reg_dump_reader_pkg::CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_firstAddr,
  input  logic [ADDR_W-1:0] i_lastAddr,
  output logic [ADDR_W-1:0] o_readAddress,
  input  logic [DATA_W-1:0] i_readData,
  output logic              o_outValid,
  input  logic              i_outReady,
  output logic [DATA_W-1:0] o_outData,
  output logic [ADDR_W-1:0] o_outAddr,
  output logic              o_outLast,
  output logic              o_busy,
  output logic              o_holdWrites,
  output logic              o_done
);

  import reg_dump_reader_pkg::*;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0]  w_remaining_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_load;
  logic              w_clr;
  logic              w_out_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_remaining <= w_remaining_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_remaining_nxt = r_remaining;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_load          = 1'b0;
    w_clr           = 1'b0;
    if (i_abort) begin
      // Abort wins over start and handshake; the pointer is left where it was.
      w_clr           = 1'b1;
      w_state_nxt     = ST_IDLE;
      w_remaining_nxt = '0;
      w_busy_nxt      = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_ptr_nxt       = i_firstAddr;
            w_remaining_nxt = range_count(i_firstAddr, i_lastAddr);
            w_busy_nxt      = 1'b1;
            w_state_nxt     = ST_RUN;
          end
        end
        ST_RUN: begin
          // Capture into an empty slot, or into one being emptied this edge.
          if ((!w_out_valid || i_outReady) && (r_remaining != '0)) begin
            w_load          = 1'b1;
            w_ptr_nxt       = r_ptr + ADDR_W'(1);
            w_remaining_nxt = r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              w_state_nxt = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Start is not looked at here, so one arriving with the final handshake is dropped.
          if (w_out_valid && i_outReady) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  dump_out_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_out_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_load  (w_load),
    .i_data  (i_readData),
    .i_addr  (r_ptr),
    .i_last  (r_remaining == CNT_W'(1)),
    .i_ready (i_outReady),
    .o_valid (w_out_valid),
    .o_data  (o_outData),
    .o_addr  (o_outAddr),
    .o_last  (o_outLast)
  );

  assign o_readAddress = r_ptr;
  assign o_outValid    = w_out_valid;
  assign o_busy        = r_busy;
  assign o_holdWrites  = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic [4:0]  read_address;
  logic [4:0]  out_addr;
  logic [31:0] read_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        hold_writes;
  logic        done;

  // Register file contents seen by the read port; also the reference data.
  logic [31:0] regs [32];

  int n_checks = 0;
  int n_errs   = 0;

  assign read_data = regs[read_address];

  always #5 clk = ~clk;

  reg_dump_reader dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_abort       (abort),
    .i_firstAddr   (first_addr),
    .i_lastAddr    (last_addr),
    .o_readAddress (read_address),
    .i_readData    (read_data),
    .o_outValid    (out_valid),
    .i_outReady    (out_ready),
    .o_outData     (out_data),
    .o_outAddr     (out_addr),
    .o_outLast     (out_last),
    .o_busy        (busy),
    .o_holdWrites  (hold_writes),
    .o_done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"},  out_data, 0);
    chk({tag, "_addr"},  32'(out_addr), 0);
    chk({tag, "_last"},  32'(out_last), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_hold"},  32'(hold_writes), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_raddr"}, 32'(read_address), 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for the first 5 valid cycles.
  // Random start pulses are thrown in while busy and must have no effect.
  task automatic run_dump(input int first, input int last, input int mode);
    int          q_addr[$];
    int          n;
    int          a;
    int          budget;
    int          stall_left;
    bit          fin;
    bit          pend_done;
    bit          stall_prev;
    logic [31:0] hd;
    logic [4:0]  ha;
    logic        hl;
    n = ((last - first + 32) % 32) + 1;
    for (int k = 0; k < n; k++) q_addr.push_back((first + k) % 32);
    first_addr = 5'(first);
    last_addr  = 5'(last);
    start      = 1'b1;
    out_ready  = 1'b1;
    step();
    start      = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("hold_after_start", 32'(hold_writes), 1);
    chk("valid_after_start", 32'(out_valid), 0);
    stall_left = 5;
    fin        = 1'b0;
    pend_done  = 1'b0;
    stall_prev = 1'b0;
    hd         = '0;
    ha         = '0;
    hl         = 1'b0;
    budget     = 400;
    while (!fin && budget > 0) begin
      chk("done_pulse", 32'(done), 32'(pend_done));
      if (pend_done) begin
        start = 1'b0;
        chk("busy_end", 32'(busy), 0);
        chk("hold_end", 32'(hold_writes), 0);
        chk("valid_end", 32'(out_valid), 0);
        fin = 1'b1;
      end else begin
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
        endcase
        if (mode == 2 && out_valid && stall_left > 0) stall_left--;
        start      = ($urandom_range(0, 5) == 0);
        first_addr = 5'($urandom);
        last_addr  = 5'($urandom);
        chk("busy_mid", 32'(busy), 1);
        chk("hold_mid", 32'(hold_writes), 1);
        if (stall_prev) begin
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_data", out_data, hd);
          chk("stall_addr", 32'(out_addr), 32'(ha));
          chk("stall_last", 32'(out_last), 32'(hl));
        end
        if (out_valid && out_ready) begin
          if (q_addr.size() == 0) begin
            chk("extra_word", 1, 0);
          end else begin
            a = q_addr.pop_front();
            chk("word_addr", 32'(out_addr), a);
            chk("word_data", out_data, regs[a]);
            chk("word_last", 32'(out_last), 32'(q_addr.size() == 0));
            if (q_addr.size() == 0) begin
              pend_done = 1'b1;
              start     = 1'b1;  // coincides with the final handshake: must be ignored
            end
          end
        end
        stall_prev = out_valid && !out_ready;
        hd         = out_data;
        ha         = out_addr;
        hl         = out_last;
      end
      if (!fin) begin
        step();
        budget--;
      end
    end
    if (!fin) chk("dump_timeout", 0, 1);
    start = 1'b0;
    step();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after", 32'(busy), 0);
    chk("idle_valid", 32'(out_valid), 0);
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[7]  = 32'd5;
    regs[17] = 32'd0;
    regs[18] = 32'd13;
    regs[19] = 32'd10;

    // Reset state.
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    run_dump(17, 19, 0);
    run_dump(30, 1, 0);
    run_dump(1, 0, 0);
    run_dump(7, 7, 2);

    // Abort while the second word of a full dump is on the output.
    first_addr = 5'd0;
    last_addr  = 5'd31;
    out_ready  = 1'b1;
    start      = 1'b1;
    step();
    start  = 1'b0;
    budget = 10;
    while (!(out_valid && out_addr == 5'd1) && budget > 0) begin
      step();
      budget--;
    end
    chk("abort_reach_word2", 32'(out_valid && out_addr == 5'd1), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_last", 32'(out_last), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_hold", 32'(hold_writes), 0);
    chk("abort_done", 32'(done), 0);
    step();
    chk("abort_done_late", 32'(done), 0);
    chk("abort_stays_idle", 32'(out_valid), 0);
    run_dump(20, 4, 1);

    // Asynchronous reset with a word held on the output.
    first_addr = 5'd3;
    last_addr  = 5'd12;
    out_ready  = 1'b0;
    start      = 1'b1;
    step();
    start  = 1'b0;
    budget = 10;
    while (!out_valid && budget > 0) begin
      step();
      budget--;
    end
    chk("rst_mid_valid_seen", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    #2;
    rst_n = 1'b1;
    step();
    chk_all_zero("rst_mid_after");
    run_dump(3, 12, 0);

    // Random ranges under random backpressure.
    for (int t = 0; t < 8; t++) begin
      run_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1);
    end
    run_dump(9, 8, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary, errors=%0d checks=%0d", n_errs, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side sequencer for the 32x32 register file; it is the counterpart to the writeback path that drives writeEnable/writeAddress/writeData.
- On a start pulse it walks a register address range, driving the file's read address and capturing the combinational read data.
- Each word is streamed out, tagged with its address, over a valid/ready handshake toward the debug/dump path.
- While active it asserts holdWrites so the pipeline stalls writeback and the dump is a coherent snapshot.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
CNT_W, ADDR_W+1, remaining-word counter width (must hold 1..2^ADDR_W)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a dump; ignored while busy
abort  input  1  synchronous cancel; returns block to IDLE
firstAddr  input  ADDR_W  first register to dump, sampled on accepted start
lastAddr  input  ADDR_W  last register to dump, sampled on accepted start
readAddress  output  ADDR_W  read address driven to the register file read port
readData  input  DATA_W  combinational read data from the register file for readAddress
outValid  output  1  outData/outAddr/outLast valid
outReady  input  1  consumer accepts the word when outValid&&outReady
outData  output  DATA_W  captured register value
outAddr  output  ADDR_W  register index of outData
outLast  output  1  current word is the final word of the dump
busy  output  1  high from accepted start until done or abort
holdWrites  output  1  equals busy; pipeline must suppress register writes while high
done  output  1  one-cycle pulse after the last word's handshake

Behaviour:
- Reset (async, rst_n=0): state=IDLE; readAddress=0, outValid=0, outData=0, outAddr=0, outLast=0, busy=0, holdWrites=0, done=0, remaining=0.
- States: IDLE, RUN, DRAIN.
- IDLE: when start=1 at a clock edge, latch ptr<=firstAddr, remaining<=((lastAddr-firstAddr) mod 2^ADDR_W)+1, busy<=1, then go to RUN. readAddress is driven directly from ptr.
- Count rules:
  - firstAddr==lastAddr gives 1 word.
  - lastAddr<firstAddr wraps through 31->0, e.g. 30..1 = 30,31,0,1 (4 words).
  - The maximum is 32 words (first=lastAddr+1 mod 32, e.g. first=1, last=0).
- RUN: a capture occurs on an edge where (!outValid || outReady) and remaining>0. On capture:
  - outData<=readData, outAddr<=ptr, outValid<=1, outLast<=(remaining==1);
  - ptr<=ptr+1 (mod 2^ADDR_W), remaining<=remaining-1.
- Throughput and latency:
  - With outReady held high the block produces 1 word per cycle.
  - The first outValid appears on the edge after the start edge.
  - If outValid=1 and outReady=0, outputs and ptr hold unchanged; no word is dropped or duplicated.
- When the final capture occurs (remaining becomes 0), go to DRAIN.
- DRAIN: on outValid&&outReady, set outValid<=0, outLast<=0, busy<=0, done<=1 for exactly one cycle, then go to IDLE.
- done is 0 in every other cycle.
- start while busy is ignored, including start in the same cycle as the final handshake.
- abort (any state, priority over start and handshake): next edge sets outValid=0, outLast=0, busy=0, remaining=0 and state=IDLE. done stays 0. ptr/readAddress hold.
- Reset mid-dump behaves the same as abort, but returns all outputs to their reset values immediately (asynchronously).
- holdWrites is combinationally equal to busy. A write presented while holdWrites=1 is a pipeline protocol violation and is not checked by this block.

Decomposition:
- Shared package:
  - ADDR_W/DATA_W constants, common with the register file;
  - state enum (IDLE, RUN, DRAIN);
  - the address-range count function ((last-first) mod 2^ADDR_W)+1.
- One natural sub-module: dump_out_reg, a single-entry valid/ready output register holding data, address and last.
- The FSM, pointer and counter stay in the top module.

Test Plan:
- Reg7=5, reg18=13, reg19=10; start with first=17,last=19, outReady=1 -> 3 consecutive words (17,0),(18,13),(19,10); outLast only on addr 19; done pulses 1 cycle after the third handshake.
- first=30,last=1 -> outAddr sequence 30,31,0,1 with 4 words; busy/holdWrites high throughout, then low after done.
- first=1,last=0 -> 32 words, addr 1..31 then 0; no wrap error; remaining counter does not overflow.
- first=last=7, outReady=0 for 5 cycles then 1 -> outValid high and stable (outData=5, outAddr=7, outLast=1) across the stall; exactly one handshake, then done.
- abort on the 2nd word of a 0..31 dump -> outValid=0 next edge, no done, busy=0; a new start afterward dumps correctly from its own firstAddr.
- rst_n asserted mid-dump with outValid=1 -> all outputs 0 immediately; start pulsed while busy -> ignored, word count unchanged.
